// File: rtl/reg_file.sv
// Operand register file: 2^ADDR_W x DATA_W storage with one write port and a
// registered dual-operand read stage using a valid/ready handshake toward the ALU.
module reg_file #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] out1_addr,
    input  logic [ADDR_W-1:0] out2_addr,
    input  logic              read_en,
    output logic              read_ready,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              load;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign out_valid  = (state == FULL);
    assign read_ready = !out_valid || out_ready;
    assign load       = read_en && read_ready;

    // Same-edge write-back is forwarded so the operand never sees a stale value
    assign rd1 = (write_en && (in_addr == out1_addr)) ? in : regs[out1_addr];
    assign rd2 = (write_en && (in_addr == out2_addr)) ? in : regs[out2_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[in_addr] <= in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A stalled FULL pair only leaves when the ALU consumes it
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (read_en) state_nxt = FULL;
            FULL:    if (out_ready && !read_en) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out1 <= '0;
            out2 <= '0;
        end else if (load) begin
            out1 <= rd1;
            out2 <= rd2;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, bypass, stall, back-to-back and async reset.
module tb_reg_file;

    logic       clk;
    logic       reset_n;
    logic [7:0] in;
    logic [2:0] in_addr;
    logic       write_en;
    logic [2:0] out1_addr;
    logic [2:0] out2_addr;
    logic       read_en;
    logic       read_ready;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       out_valid;
    logic       out_ready;

    int vecs;
    int errs;

    reg_file #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in        (in),
        .in_addr   (in_addr),
        .write_en  (write_en),
        .out1_addr (out1_addr),
        .out2_addr (out2_addr),
        .read_en   (read_en),
        .read_ready(read_ready),
        .out1      (out1),
        .out2      (out2),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in = 8'hAA; in_addr = 3'd1; write_en = 1'b1;
        out1_addr = 3'd1; out2_addr = 3'd1; read_en = 1'b1; out_ready = 1'b0;
        #1;
        vecs++;
        if (out1 !== 8'h00 || out2 !== 8'h00 || out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_outputs: got %h/%h/%b expected 00/00/0", out1, out2, out_valid);
        end
        vecs++;
        if (read_ready !== 1'b1) begin
            errs++; $display("FAIL reset_read_ready: got %b expected 1", read_ready);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b0 || out1 !== 8'h00) begin
            errs++; $display("FAIL reset_ignores_io: got %h/%b expected 00/0", out1, out_valid);
        end
        // Release; the write attempted during reset must not have landed in r1
        reset_n = 1'b1; write_en = 1'b0; out_ready = 1'b1;
        tick();
        vecs++;
        if (out1 !== 8'h00 || out_valid !== 1'b1) begin
            errs++; $display("FAIL reset_write_ignored: got %h/%b expected 00/1", out1, out_valid);
        end
        read_en = 1'b0;
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL drain_to_empty: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_write_read();
        write_en = 1'b1; in_addr = 3'd1; in = 8'd25;
        tick();
        in_addr = 3'd2; in = 8'd3;
        tick();
        write_en = 1'b0; read_en = 1'b1; out1_addr = 3'd1; out2_addr = 3'd2; out_ready = 1'b1;
        tick();
        vecs++;
        if (out1 !== 8'd25 || out2 !== 8'd3 || out_valid !== 1'b1) begin
            errs++; $display("FAIL write_read: got %0d/%0d/%b expected 25/3/1", out1, out2, out_valid);
        end
        read_en = 1'b0;
        tick();
        vecs++;
        if (out1 !== 8'd25 || out2 !== 8'd3 || out_valid !== 1'b0) begin
            errs++; $display("FAIL empty_hold: got %0d/%0d/%b expected 25/3/0", out1, out2, out_valid);
        end
    endtask

    task automatic test_bypass();
        write_en = 1'b1; in_addr = 3'd4; in = 8'hFB;
        read_en = 1'b1; out1_addr = 3'd4; out2_addr = 3'd4; out_ready = 1'b1;
        tick();
        vecs++;
        if (out1 !== 8'hFB || out2 !== 8'hFB || out_valid !== 1'b1) begin
            errs++; $display("FAIL bypass_both: got %h/%h/%b expected fb/fb/1", out1, out2, out_valid);
        end
        in_addr = 3'd5; in = 8'd7; out1_addr = 3'd5; out2_addr = 3'd1;
        tick();
        vecs++;
        if (out1 !== 8'd7 || out2 !== 8'd25) begin
            errs++; $display("FAIL bypass_one_port: got %0d/%0d expected 7/25", out1, out2);
        end
        write_en = 1'b0; read_en = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        read_en = 1'b1; out1_addr = 3'd1; out2_addr = 3'd2; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; write_en = 1'b1; in_addr = 3'd1; in = 8'd8;
        out1_addr = 3'd1; out2_addr = 3'd1;
        #1;
        vecs++;
        if (read_ready !== 1'b0) begin
            errs++; $display("FAIL stall_read_ready: got %b expected 0", read_ready);
        end
        tick();
        vecs++;
        if (out1 !== 8'd25 || out2 !== 8'd3 || out_valid !== 1'b1) begin
            errs++; $display("FAIL stall_hold: got %0d/%0d/%b expected 25/3/1", out1, out2, out_valid);
        end
        write_en = 1'b0;
        tick();
        vecs++;
        if (out1 !== 8'd25 || out2 !== 8'd3 || out_valid !== 1'b1) begin
            errs++; $display("FAIL stall_hold2: got %0d/%0d/%b expected 25/3/1", out1, out2, out_valid);
        end
        out_ready = 1'b1;
        #1;
        vecs++;
        if (read_ready !== 1'b1) begin
            errs++; $display("FAIL unstall_read_ready: got %b expected 1", read_ready);
        end
        tick();
        vecs++;
        if (out1 !== 8'd8 || out2 !== 8'd8 || out_valid !== 1'b1) begin
            errs++; $display("FAIL stall_release: got %0d/%0d/%b expected 8/8/1", out1, out2, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] a1 [3];
        logic [2:0] a2 [3];
        logic [7:0] e1 [3];
        logic [7:0] e2 [3];
        // r1=8 r2=3 r4=fb r5=7 at this point
        a1 = '{3'd1, 3'd4, 3'd2}; a2 = '{3'd2, 3'd5, 3'd4};
        e1 = '{8'd8, 8'hFB, 8'd3}; e2 = '{8'd3, 8'd7, 8'hFB};
        read_en = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            out1_addr = a1[k]; out2_addr = a2[k];
            tick();
            vecs++;
            if (out1 !== e1[k] || out2 !== e2[k] || out_valid !== 1'b1) begin
                errs++;
                $display("FAIL back_to_back[%0d]: got %h/%h/%b expected %h/%h/1", k, out1, out2, out_valid, e1[k], e2[k]);
            end
        end
        read_en = 1'b0;
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL b2b_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_empty_out_ready();
        out_ready = 1'b1; read_en = 1'b0;
        tick();
        out_ready = 1'b0;
        tick();
        vecs++;
        if (out_valid !== 1'b0 || out1 !== 8'd3 || out2 !== 8'hFB) begin
            errs++; $display("FAIL empty_out_ready: got %h/%h/%b expected 03/fb/0", out1, out2, out_valid);
        end
    endtask

    task automatic test_async_reset();
        read_en = 1'b1; out1_addr = 3'd1; out2_addr = 3'd2; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; out1_addr = 3'd1; out2_addr = 3'd1;
        vecs++;
        if (out1 !== 8'd8 || out_valid !== 1'b1) begin
            errs++; $display("FAIL pre_reset_pair: got %0d/%b expected 8/1", out1, out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        vecs++;
        if (out1 !== 8'h00 || out2 !== 8'h00 || out_valid !== 1'b0 || read_ready !== 1'b1) begin
            errs++;
            $display("FAIL async_reset: got %h/%h/%b/%b expected 00/00/0/1", out1, out2, out_valid, read_ready);
        end
        #1 reset_n = 1'b1;
        tick();
        vecs++;
        if (out1 !== 8'h00 || out2 !== 8'h00 || out_valid !== 1'b1) begin
            errs++; $display("FAIL post_reset_read: got %h/%h/%b expected 00/00/1", out1, out2, out_valid);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_back_to_back();
        test_empty_out_ready();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the register and data width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 3, giving the address width; register count is 2^ADDR_W (8).
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port in  input  DATA_W  write data (ALU result write-back).
REQ-007 Port in_addr  input  ADDR_W  write register address.
REQ-008 Port write_en  input  1  write strobe.
REQ-009 Port out1_addr  input  ADDR_W  read address for operand 1.
REQ-010 Port out2_addr  input  ADDR_W  read address for operand 2.
REQ-011 Port read_en  input  1  operand-fetch request.
REQ-012 Port read_ready  output  1  high when a read request is accepted this cycle.
REQ-013 Port out1  output  DATA_W  registered operand 1, driving ALU data1.
REQ-014 Port out2  output  DATA_W  registered operand 2, driving ALU data2.
REQ-015 Port out_valid  output  1  high while out1/out2 hold an unconsumed operand pair.
REQ-016 Port out_ready  input  1  ALU-side consume strobe.

Function
REQ-017 Storage SHALL be 2^ADDR_W registers of DATA_W bits; contents are treated as raw bits (two's-complement meaning belongs to the ALU).
REQ-018 On a rising edge with write_en=1, regs[in_addr] SHALL take in; with write_en=0, no register changes.
REQ-019 read_ready SHALL be combinational: !out_valid || out_ready.
REQ-020 A read is accepted on a rising edge where read_en=1 and read_ready=1; out1/out2 SHALL update on that edge (latency 1 cycle) and out_valid SHALL become 1.
REQ-021 Bypass: if write_en=1 and in_addr equals out1_addr on the accepting edge, out1 SHALL take in instead of the stored value; same rule applies to out2 with out2_addr.
REQ-022 Both read addresses equal: out1 and out2 SHALL carry the same value, including under bypass.
REQ-023 Output controller SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-024 EMPTY -> FULL on an accepted read; EMPTY with read_en=0 stays EMPTY.
REQ-025 FULL with out_ready=1 and read_en=1 SHALL stay FULL and load the new pair (back-to-back, one pair per cycle).
REQ-026 FULL with out_ready=1 and read_en=0 SHALL go to EMPTY; out1/out2 hold their last values.
REQ-027 FULL with out_ready=0 SHALL stall: out1, out2, out_valid unchanged, read request ignored and must be held by the requester.
REQ-028 Writes SHALL proceed during a stall; a held operand pair SHALL NOT be updated by a later write (no retroactive bypass).
REQ-029 out_ready while EMPTY SHALL have no effect.

Reset
REQ-030 reset_n=0 SHALL immediately, without a clock edge, clear all registers, out1, out2 and out_valid to 0 and force state EMPTY.
REQ-031 While reset_n=0, writes and reads SHALL be ignored; read_ready reads 1.
REQ-032 Reset asserted mid-stall SHALL discard the held pair; the first edge after reset_n rises behaves as from EMPTY.

Verification
REQ-033 Write 25 to r1 and 3 to r2, then read_en with addrs 1,2 and out_ready=1 -> one edge later out1=25, out2=3, out_valid=1.
REQ-034 On the same edge, write -5 (8'hFB) to r4 and read addrs 4,4 -> out1=out2=8'hFB (bypass).
REQ-035 Hold out_ready=0 with out_valid=1 while writing 8 to r1 and requesting addrs 1,1 -> read_ready=0, outputs hold the old pair; raise out_ready -> next edge loads 8,8.
REQ-036 Issue reads on three consecutive edges with out_ready=1 -> three distinct pairs, one per cycle, out_valid never drops.
REQ-037 After loading regs, pulse reset_n low between clock edges -> out1=out2=0 and out_valid=0 immediately; a subsequent read of r1 returns 0.
